down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Synchronous modulo down counter: the down-direction counterpart of the team's toggle-based up counters.
- Supports parallel load, count enable, free-running or one-shot mode, and a registered terminal-count pulse.
- Used as a programmable timer / clock-enable divider beside the existing up counters.
- One clock domain, no internal clock gating.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 1.
- RELOAD_VAL, 2**WIDTH-1, value taken at reset and on free-running wrap; must satisfy 1 <= RELOAD_VAL < 2**WIDTH, else elaboration error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset, sampled on rising clk
- en  input  1  count enable; decrement on each enabled edge
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value loaded when load=1
- one_shot  input  1  1 = stop at zero; 0 = wrap to RELOAD_VAL
- q  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered, one cycle wide)
- busy  output  1  high while state is RUN

Behaviour:
- All state changes occur on the rising edge of clk. Priority order: reset, then load, then en.
- Reset (reset=0 at the edge):
  - q = RELOAD_VAL, tc = 0, state = IDLE, busy = 0.
  - Reset overrides a simultaneous load or en.
- States: IDLE (after reset only), RUN, HALT. busy = (state == RUN).
- load=1, in any state:
  - q <= load_val, state <= RUN, tc <= 0.
  - No decrement on that edge; en is ignored on that edge.
- IDLE with en=1 and load=0: behaves exactly as RUN for that edge, and state <= RUN.
- RUN (or IDLE) with en=1 and load=0:
  - q != 0: q <= q-1, tc <= 0.
  - q == 0: tc <= 1 for exactly one cycle. one_shot is sampled on this edge:
    - one_shot=1: q stays 0, state <= HALT.
    - one_shot=0: q <= RELOAD_VAL, state stays RUN.
- en=0: q and state hold, tc <= 0.
- HALT: en ignored, q = 0, tc = 0, busy = 0. The only exits are load or reset.
- Latency:
  - tc is asserted on the edge after the edge that observed q == 0 with en=1.
  - Free-running period is RELOAD_VAL+1 enabled cycles.
  - load_val = L gives a first tc after L+1 enabled cycles; load_val = 0 gives tc on the first enabled edge after the load.
- Width rules: all arithmetic is WIDTH bits unsigned. Never decrement below 0; zero is always handled as the wrap/halt case, never as a modulo underflow.
- en is allowed to toggle every cycle; count progress depends only on the number of enabled edges.

Optional Feature:
- Macro: DOWN_COUNTER_TOG_EN.
- Defined:
  - Adds output port tog (1 bit), reset value 0.
  - tog inverts on every edge where tc is set to 1, giving a 50%-duty divide-by-2*(RELOAD_VAL+1) output in free-running mode.
  - load does not affect tog.
- Undefined: tog port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package counter_pkg holds:
  - enum typedef cnt_state_t {IDLE, RUN, HALT} with fixed 2-bit encodings 00/01/10.
  - Helper constant function for the RELOAD_VAL range check.
- One sub-module is natural: tff_sync, a synchronous active-low-reset T flip-flop (ports clk, reset, t, q).
  - Instantiated for tog with t = next-cycle tc.
  - Instantiated only under DOWN_COUNTER_TOG_EN.

Test Plan:
- Reset: WIDTH=4, hold reset=0 for 2 cycles with load=1, load_val=7 -> q=15, tc=0, busy=0 (and tog=0 when the macro is defined).
- Free-run: release reset, en=1 constant, one_shot=0 -> q goes 14,13,...,0,15,...; tc high for one cycle after each q=0 edge, every 16 cycles; busy=1.
- Load mid-count: at q=9 apply load=1, load_val=3, en=1 -> next q=3 (no decrement), then 2,1,0; tc 4 enabled cycles after the load.
- One-shot with en gaps: load 2, one_shot=1, en=1 except en=0 for 3 cycles at q=1 -> q holds 1 during the gap, then 0; a single tc pulse; q stays 0, busy=0; further en ignored. load_val=5 then restarts with busy=1.
- Reset mid-run plus edge cases:
  - At q=4 assert reset=0 with load=1 -> q=15, IDLE, tc=0.
  - load_val=0 then en=1 -> tc on the next edge.
- DOWN_COUNTER_TOG_EN defined, free-run -> tog toggles on each tc; tog period is 32 cycles with 16 high and 16 low.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Types and helpers shared by the counter family.
//   cnt_state_t     : down_counter control state (IDLE/RUN/HALT, fixed encoding)
//   reload_val_ok() : range check for the reload constant, used at elaboration
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } cnt_state_t;

    // Reload must be a non-zero value that fits in the counter width.
    function automatic bit reload_val_ok(input int width, input longint unsigned val);
        if (width < 1) begin
            return 1'b0;
        end
        if (width >= 64) begin
            return val >= 64'd1;
        end
        return (val >= 64'd1) && (val < (64'd1 << width));
    endfunction

endpackage

// File: rtl/tff_sync.sv
// -----------------------------------------------------------------------------
// tff_sync
// T flip-flop with synchronous active-low reset.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset (q -> 0)
//   t     : toggle request, q inverts on the edge when t = 1
//   q     : registered output
// -----------------------------------------------------------------------------
module tff_sync (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Synchronous modulo down counter with parallel load, count enable,
// free-running / one-shot mode and a registered terminal-count pulse.
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset
//   en       : count enable, one decrement per enabled edge
//   load     : parallel load strobe (beats en)
//   load_val : value loaded when load = 1
//   one_shot : 1 = stop at zero (HALT), 0 = wrap to RELOAD_VAL
//   q        : current count
//   tc       : one-cycle terminal-count pulse, the edge after q == 0 is counted
//   busy     : high while in RUN
//   tog      : divide-by-2*(RELOAD_VAL+1) square wave, flips on every tc
//              (present only when DOWN_COUNTER_TOG_EN is defined)
// -----------------------------------------------------------------------------
module down_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH      = 4,
    parameter int unsigned RELOAD_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
`ifdef DOWN_COUNTER_TOG_EN
    output logic             tog,
`endif
    output logic             busy
);

    if (!reload_val_ok(WIDTH, 64'(RELOAD_VAL))) begin : g_bad_reload
        $error("down_counter: RELOAD_VAL must satisfy 1 <= RELOAD_VAL < 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(RELOAD_VAL);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;

        if (load) begin
            cnt_d   = load_val;
            state_d = RUN;
        end else if (en && (state_q != HALT)) begin
            // IDLE counts exactly like RUN and moves to RUN on its first edge.
            if (cnt_q != '0) begin
                cnt_d   = cnt_q - WIDTH'(1);
                state_d = RUN;
            end else begin
                // Zero is the wrap/halt point, never a modulo underflow.
                tc_d = 1'b1;
                if (one_shot) begin
                    cnt_d   = '0;
                    state_d = HALT;
                end else begin
                    cnt_d   = RELOAD;
                    state_d = RUN;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= RELOAD;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign busy = (state_q == RUN);

`ifdef DOWN_COUNTER_TOG_EN
    // Toggle on the same edge that raises tc; load never touches it.
    tff_sync u_tog (
        .clk   (clk),
        .reset (reset),
        .t     (tc_d),
        .q     (tog)
    );
`endif

endmodule

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
// Self-checking bench for down_counter (WIDTH = 4, RELOAD_VAL = 15).
// Define DOWN_COUNTER_TOG_EN to also cover the tog output.
// -----------------------------------------------------------------------------
module tb_down_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       one_shot;
    logic [3:0] q;
    logic       tc;
    logic       busy;
`ifdef DOWN_COUNTER_TOG_EN
    logic       tog;
`endif

    int checks = 0;
    int errors = 0;

    down_counter #(.WIDTH(4), .RELOAD_VAL(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .one_shot (one_shot),
        .q        (q),
        .tc       (tc),
`ifdef DOWN_COUNTER_TOG_EN
        .tog      (tog),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       os;
        logic [3:0] exp_q;
        logic       exp_tc;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rst, logic ld, logic [3:0] lv, logic e, logic os,
                               logic [3:0] eq, logic etc, logic eb);
        vec_t r;
        r.rst = rst; r.ld = ld; r.lv = lv; r.en = e; r.os = os;
        r.exp_q = eq; r.exp_tc = etc; r.exp_busy = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, advance one rising edge, then sample 1 time unit later.
    task automatic step(input logic rst, input logic ld, input logic [3:0] lv,
                        input logic e, input logic os);
        reset = rst; load = ld; load_val = lv; en = e; one_shot = os;
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step(tbl[i].rst, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].os);
            check($sformatf("row%0d.q", i),    32'(q),    32'(tbl[i].exp_q));
            check($sformatf("row%0d.tc", i),   32'(tc),   32'(tbl[i].exp_tc));
            check($sformatf("row%0d.busy", i), 32'(busy), 32'(tbl[i].exp_busy));
        end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; one_shot = 1'b0;

        //             rst ld  lv  en os   q  tc busy
        // rows 0-3: reset beats load/en, IDLE hold, first count
        tbl.push_back(v(0, 1, 7, 1, 0, 15, 0, 0));
        tbl.push_back(v(0, 1, 7, 1, 0, 15, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 15, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 14, 0, 1));
        // rows 4-12: from q=12, count to 9 then load 3 mid-count
        tbl.push_back(v(1, 0, 0, 1, 0, 11, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 10, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0,  9, 0, 1));
        tbl.push_back(v(1, 1, 3, 1, 0,  3, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0,  2, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0,  1, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 15, 1, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 14, 0, 1));
        // rows 13-24: one-shot with an en gap, HALT, restart by load
        tbl.push_back(v(1, 1, 2, 1, 1,  2, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 1,  1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 1,  1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 1,  1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 1,  1, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 1,  0, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 1,  0, 1, 0));
        tbl.push_back(v(1, 0, 0, 1, 1,  0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0,  0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(v(1, 1, 5, 1, 1,  5, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 1,  4, 0, 1));
        // rows 25-35: reset mid-run with load, load_val = 0 cases
        tbl.push_back(v(1, 0, 0, 0, 1,  4, 0, 1));
        tbl.push_back(v(0, 1, 9, 1, 0, 15, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 15, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 15, 1, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 14, 0, 1));
        tbl.push_back(v(1, 1, 0, 1, 1,  0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 1,  0, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 1,  0, 1, 0));
        tbl.push_back(v(1, 1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 15, 1, 1));

        run_rows(0, 3);
`ifdef DOWN_COUNTER_TOG_EN
        check("reset.tog", 32'(tog), 32'd0);
`endif

        // Free-run: q was 14 after row 3; after k more edges q = (14-k) mod 16,
        // tc high exactly on the edges where q wrapped to 15.
        for (int k = 1; k <= 34; k++) begin
            int eq;
            step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
            eq = (((14 - k) % 16) + 16) % 16;
            check($sformatf("free%0d.q", k),    32'(q),    32'(eq));
            check($sformatf("free%0d.tc", k),   32'(tc),   32'(eq == 15));
            check($sformatf("free%0d.busy", k), 32'(busy), 32'd1);
        end

        run_rows(4, tbl.size() - 1);

        // en toggling every cycle: progress counts enabled edges only.
        step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            logic e;
            e = (k % 2 == 1);
            step(1'b1, 1'b0, 4'd0, e, 1'b0);
            // after k edges, (k+1)/2 enabled edges have occurred
            if ((k + 1) / 2 < 4) begin
                check($sformatf("alt%0d.q", k), 32'(q), 32'(3 - (k + 1) / 2));
                check($sformatf("alt%0d.tc", k), 32'(tc), 32'd0);
            end else begin
                check($sformatf("alt%0d.q", k), 32'(q), 32'd15);
                check($sformatf("alt%0d.tc", k), 32'(tc), 32'(k == 7));
            end
        end

`ifdef DOWN_COUNTER_TOG_EN
        // tog: from reset, free-run; tc at edges 16,32,48,64 so tog = (k/16)%2.
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("tog.reset", 32'(tog), 32'd0);
        for (int k = 1; k <= 64; k++) begin
            step(1'b1, (k == 8), 4'd7, 1'b1, 1'b0);
            if (k <= 7) begin
                check($sformatf("tog%0d", k), 32'(tog), 32'd0);
            end
            if (k == 8) begin
                // load at k = 8 restarts from 7: next tc 8 edges later, at k=16
                check("tog.load.q", 32'(q), 32'd7);
                check("tog.load", 32'(tog), 32'd0);
            end
            if (k > 8) begin
                check($sformatf("tog%0d", k), 32'(tog), 32'((k / 16) % 2));
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
